// File: rtl/msf_timebase_pkg.sv
// Shared constants and types for the MSF / DCF77 carrier timebase.
package msf_timebase_pkg;

  localparam int unsigned FRANKFURT_MAX      = 77499;
  localparam int unsigned MSF_MAX            = 59999;
  localparam int unsigned DEFAULT_DECIM_LOG2 = 7;

  typedef enum logic {
    SLIP_RETARD  = 1'b0,
    SLIP_ADVANCE = 1'b1
  } slip_dir_e;

  // Both BRAM write strobes drive all four byte lanes together.
  function automatic logic [3:0] byte_strobe(input logic fire);
    return {4{fire}};
  endfunction

endpackage

// File: rtl/msf_strobe_delay.sv
// Fixed-length single-bit delay line with a synchronous flush, used to
// schedule the BRAM write strobes a set number of clocks after their trigger.
module msf_strobe_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic strobe_i,
  output logic strobe_o
);

  logic [DEPTH-1:0] pipe_q;

  // Shift the trigger toward the output; a clear drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | DEPTH'(strobe_i);
    end
  end

  assign strobe_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/msf_timebase.sv
// Carrier / second / minute timebase for a time-signal receiver. The carrier
// counter addresses the second BRAM, the second counter addresses the minute
// BRAM, and phase slips let the recovery loop nudge the count by one.
module msf_timebase
  import msf_timebase_pkg::*;
#(
  parameter int CNT_W          = 17,
  parameter int SECONDS_MINUTE = 59,
  parameter int DECIM_LOG2     = DEFAULT_DECIM_LOG2,
  parameter int SEC_WR_DELAY   = 3,
  parameter int MIN_WR_DELAY   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             carrier_pulse,
  input  logic [CNT_W-1:0] carrier_max,
  input  logic [CNT_W-1:0] marker_pos,
  input  logic             slip_req,
  input  logic             slip_dir,
  output logic [CNT_W-1:0] carrier_counter,
  output logic [5:0]       second_counter,
  output logic [15:0]      minute_counter,
  output logic             one_sec_marker,
  output logic             one_min_marker,
  output logic [3:0]       write_second_bram,
  output logic [3:0]       write_minute_bram,
  output logic             slip_pending,
  output logic             config_err
);

  localparam logic [5:0] SEC_LAST = 6'(SECONDS_MINUTE);

  logic [CNT_W-1:0] carrier_q, carrier_d;
  logic [5:0]       sec_q, sec_d;
  logic [15:0]      min_q, min_d;
  logic             marker_eq_q, marker_eq_d;
  logic             one_sec_q, one_sec_d;
  logic             one_min_q, one_min_d;
  logic             slip_pending_q, slip_pending_d;
  slip_dir_e        slip_dir_q, slip_dir_d;
  logic             config_err_q, config_err_d;

  logic [CNT_W-1:0] carrier_wrap;
  logic             swallow;
  logic             advance;
  logic             count_pulse;
  logic             sec_qualify;
  logic             marker_eq;
  logic             sec_edge;
  logic             sec_wrap;
  logic             sec_wr_fire;
  logic             min_wr_fire;
  logic             pipe_clear;

  // Next-state logic: carrier stepping, slip handling, second/minute roll-over.
  always_comb begin
    carrier_wrap = (carrier_q >= carrier_max) ? '0 : carrier_q + CNT_W'(1);
    swallow      = en && slip_pending_q && (slip_dir_q == SLIP_RETARD) && carrier_pulse;
    advance      = en && slip_pending_q && (slip_dir_q == SLIP_ADVANCE) && !carrier_pulse;
    count_pulse  = en && carrier_pulse && !swallow;
    sec_qualify  = count_pulse && (carrier_q[DECIM_LOG2-1:0] == '0);
    marker_eq    = (carrier_q == marker_pos);
    sec_edge     = en && marker_eq && !marker_eq_q;
    sec_wrap     = (sec_q >= SEC_LAST);

    carrier_d = carrier_q;
    if (count_pulse || advance) begin
      carrier_d = carrier_wrap;
    end

    slip_pending_d = slip_pending_q;
    slip_dir_d     = slip_dir_q;
    if (swallow || advance) begin
      slip_pending_d = 1'b0;
    end
    if (en && slip_req && !slip_pending_q) begin
      slip_pending_d = 1'b1;
      slip_dir_d     = slip_dir_e'(slip_dir);
    end

    sec_d     = sec_q;
    min_d     = min_q;
    one_sec_d = 1'b0;
    one_min_d = 1'b0;
    if (sec_edge) begin
      one_sec_d = 1'b1;
      if (sec_wrap) begin
        sec_d     = '0;
        min_d     = min_q + 16'd1;
        one_min_d = 1'b1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    marker_eq_d  = en ? marker_eq : marker_eq_q;
    config_err_d = config_err_q || (marker_pos > carrier_max);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier_q      <= '0;
      sec_q          <= '0;
      min_q          <= '0;
      marker_eq_q    <= 1'b0;
      one_sec_q      <= 1'b0;
      one_min_q      <= 1'b0;
      slip_pending_q <= 1'b0;
      slip_dir_q     <= SLIP_RETARD;
      config_err_q   <= 1'b0;
    end else begin
      carrier_q      <= carrier_d;
      sec_q          <= sec_d;
      min_q          <= min_d;
      marker_eq_q    <= marker_eq_d;
      one_sec_q      <= one_sec_d;
      one_min_q      <= one_min_d;
      slip_pending_q <= slip_pending_d;
      slip_dir_q     <= slip_dir_d;
      config_err_q   <= config_err_d;
    end
  end

  // Disabling the block flushes any strobe still travelling down a delay line.
  assign pipe_clear = rst || !en;

  msf_strobe_delay #(
    .DEPTH (SEC_WR_DELAY)
  ) u_sec_wr_delay (
    .clk_i    (clk),
    .clear_i  (pipe_clear),
    .strobe_i (sec_qualify),
    .strobe_o (sec_wr_fire)
  );

  msf_strobe_delay #(
    .DEPTH (MIN_WR_DELAY)
  ) u_min_wr_delay (
    .clk_i    (clk),
    .clear_i  (pipe_clear),
    .strobe_i (one_sec_marker),
    .strobe_o (min_wr_fire)
  );

  assign carrier_counter   = carrier_q;
  assign second_counter    = sec_q;
  assign minute_counter    = min_q;
  assign one_sec_marker    = one_sec_q && en;
  assign one_min_marker    = one_min_q && en;
  assign write_second_bram = byte_strobe(sec_wr_fire && en);
  assign write_minute_bram = byte_strobe(min_wr_fire && en);
  assign slip_pending      = slip_pending_q;
  assign config_err        = config_err_q;

endmodule

// File: tb/tb_msf_timebase.sv
// Bench for msf_timebase: small carrier model, event queues for markers and
// BRAM strobes, and targeted checks around slips, enable, reset and config.
module tb_msf_timebase;
  import msf_timebase_pkg::*;

  localparam int CNT_W    = 17;
  localparam int SEC_LAST = 3;
  localparam int DECIM    = 2;
  localparam int SEC_DLY  = 3;
  localparam int MIN_DLY  = 4;
  localparam int CAR_MAX  = 99;
  localparam int MARK     = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             carrier_pulse;
  logic [CNT_W-1:0] carrier_max;
  logic [CNT_W-1:0] marker_pos;
  logic             slip_req;
  logic             slip_dir;
  logic [CNT_W-1:0] carrier_counter;
  logic [5:0]       second_counter;
  logic [15:0]      minute_counter;
  logic             one_sec_marker;
  logic             one_min_marker;
  logic [3:0]       write_second_bram;
  logic [3:0]       write_minute_bram;
  logic             slip_pending;
  logic             config_err;

  msf_timebase #(
    .CNT_W          (CNT_W),
    .SECONDS_MINUTE (SEC_LAST),
    .DECIM_LOG2     (DECIM),
    .SEC_WR_DELAY   (SEC_DLY),
    .MIN_WR_DELAY   (MIN_DLY)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .carrier_pulse     (carrier_pulse),
    .carrier_max       (carrier_max),
    .marker_pos        (marker_pos),
    .slip_req          (slip_req),
    .slip_dir          (slip_dir),
    .carrier_counter   (carrier_counter),
    .second_counter    (second_counter),
    .minute_counter    (minute_counter),
    .one_sec_marker    (one_sec_marker),
    .one_min_marker    (one_min_marker),
    .write_second_bram (write_second_bram),
    .write_minute_bram (write_minute_bram),
    .slip_pending      (slip_pending),
    .config_err        (config_err)
  );

  // Free-running clock and cycle index shared by stimulus and monitor.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int cyc;
    int sec;
    int minFlag;
    int minute;
  } markExp_t;

  int       swrQ[$];
  int       mwrQ[$];
  markExp_t markQ[$];
  int       secSeq[$];
  int       swrSeen = 0;
  int       mwrSeen = 0;
  int       markSeen = 0;
  markExp_t monE;

  bit tbRst = 1'b1;
  bit tbEn = 1'b1;
  int tbMarker = MARK;

  int mCount = 0;
  int mSec = 0;
  int mMin = 0;
  bit mPending = 1'b0;
  bit mDir = 1'b0;

  int expSeq[5] = '{1, 2, 3, 0, 1};
  int base;
  int base2;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int nextCount(input int x);
    return (x >= CAR_MAX) ? 0 : x + 1;
  endfunction

  // Reference behaviour of one clock cycle; pushes the events it predicts.
  task automatic modelStep(input int c, input bit pulse, input bit req, input bit dir);
    int oldCount;
    bit wasPending;
    markExp_t e;
    oldCount   = mCount;
    wasPending = mPending;
    if (tbRst) begin
      mCount = 0; mSec = 0; mMin = 0; mPending = 1'b0; mDir = 1'b0;
      return;
    end
    if (!tbEn) return;
    if (wasPending && mDir == 1'b0 && pulse) begin
      mPending = 1'b0;
    end else if (wasPending && mDir == 1'b1 && !pulse) begin
      mCount   = nextCount(mCount);
      mPending = 1'b0;
    end else if (pulse) begin
      if ((mCount % (1 << DECIM)) == 0) swrQ.push_back(c + SEC_DLY);
      mCount = nextCount(mCount);
    end
    if (req && !wasPending) begin
      mPending = 1'b1;
      mDir     = dir;
    end
    if (mCount != oldCount && mCount == tbMarker) begin
      e.minFlag = 0;
      if (mSec == SEC_LAST) begin
        mSec = 0; mMin = mMin + 1; e.minFlag = 1;
      end else begin
        mSec = mSec + 1;
      end
      e.cyc = c + 2; e.sec = mSec; e.minute = mMin;
      markQ.push_back(e);
      mwrQ.push_back(c + 2 + MIN_DLY);
    end
  endtask

  // Drive one cycle of inputs, check the registered state, advance the model.
  task automatic applyStimulus(input bit pulse, input bit req = 1'b0, input bit dir = 1'b0);
    int c;
    int lim;
    @(posedge clk);
    #1;
    rst = tbRst; en = tbEn; marker_pos = CNT_W'(tbMarker);
    carrier_pulse = pulse; slip_req = req; slip_dir = dir;
    c = cyc;
    if (tbRst || !tbEn) begin
      lim = tbRst ? c + 1 : c;
      while (swrQ.size() > 0 && swrQ[swrQ.size()-1] >= lim) void'(swrQ.pop_back());
      while (mwrQ.size() > 0 && mwrQ[mwrQ.size()-1] >= lim) void'(mwrQ.pop_back());
      while (markQ.size() > 0 && markQ[markQ.size()-1].cyc >= lim) void'(markQ.pop_back());
    end
    @(negedge clk);
    checkOutput("carrier_counter", carrier_counter, mCount);
    checkOutput("slip_pending", slip_pending, mPending);
    modelStep(c, pulse, req, dir);
  endtask

  task automatic pulseGroup(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1);
      repeat (3) applyStimulus(1'b0);
    end
  endtask

  // Event monitor: pops predicted markers and strobes as the DUT emits them.
  always @(negedge clk) begin
    while (swrQ.size() > 0 && swrQ[0] < cyc) begin
      checkOutput("swr_missing", cyc, swrQ[0]);
      void'(swrQ.pop_front());
    end
    while (mwrQ.size() > 0 && mwrQ[0] < cyc) begin
      checkOutput("mwr_missing", cyc, mwrQ[0]);
      void'(mwrQ.pop_front());
    end
    while (markQ.size() > 0 && markQ[0].cyc < cyc) begin
      checkOutput("mark_missing", cyc, markQ[0].cyc);
      void'(markQ.pop_front());
    end
    if (write_second_bram != 4'h0) begin
      swrSeen++;
      if (swrQ.size() == 0) checkOutput("swr_unexpected", write_second_bram, 0);
      else begin
        checkOutput("swr_cycle", cyc, swrQ[0]);
        checkOutput("swr_value", write_second_bram, 4'hF);
        void'(swrQ.pop_front());
      end
    end
    if (write_minute_bram != 4'h0) begin
      mwrSeen++;
      if (mwrQ.size() == 0) checkOutput("mwr_unexpected", write_minute_bram, 0);
      else begin
        checkOutput("mwr_cycle", cyc, mwrQ[0]);
        checkOutput("mwr_value", write_minute_bram, 4'hF);
        void'(mwrQ.pop_front());
      end
    end
    if (one_sec_marker) begin
      markSeen++;
      secSeq.push_back(int'(second_counter));
      if (markQ.size() == 0) checkOutput("mark_unexpected", one_sec_marker, 0);
      else begin
        monE = markQ.pop_front();
        checkOutput("mark_cycle", cyc, monE.cyc);
        checkOutput("mark_sec", second_counter, monE.sec);
        checkOutput("mark_min_flag", one_min_marker, monE.minFlag);
        checkOutput("mark_minute", minute_counter, monE.minute);
      end
    end else if (one_min_marker) begin
      checkOutput("min_marker_alone", one_min_marker, 0);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; carrier_pulse = 1'b0; slip_req = 1'b0; slip_dir = 1'b0;
    carrier_max = CNT_W'(CAR_MAX); marker_pos = CNT_W'(MARK);
    repeat (2) @(posedge clk);

    $display("[TB] reset state");
    tbRst = 1'b1;
    applyStimulus(1'b0);
    tbRst = 1'b0;
    applyStimulus(1'b0);
    checkOutput("rst_sec", second_counter, 0);
    checkOutput("rst_min", minute_counter, 0);
    checkOutput("rst_one_sec", one_sec_marker, 0);
    checkOutput("rst_one_min", one_min_marker, 0);
    checkOutput("rst_swr", write_second_bram, 0);
    checkOutput("rst_mwr", write_minute_bram, 0);
    checkOutput("rst_cfg", config_err, 0);

    $display("[TB] decimated second-BRAM writes over counts 0..15");
    base = swrSeen;
    pulseGroup(16);
    checkOutput("decim_writes", swrSeen - base, 4);

    $display("[TB] five seconds of carrier");
    pulseGroup(394);
    repeat (8) applyStimulus(1'b0);
    checkOutput("sec_seq_len", secSeq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < secSeq.size()) checkOutput("sec_seq", secSeq[i], expSeq[i]);
    end
    checkOutput("sec_final", second_counter, 1);
    checkOutput("min_final", minute_counter, 1);

    $display("[TB] advance slip at count 9, second request dropped");
    pulseGroup(99);
    checkOutput("pre_adv_cnt", carrier_counter, 9);
    base = markSeen;
    applyStimulus(1'b0, 1'b1, SLIP_ADVANCE);
    applyStimulus(1'b0, 1'b1, SLIP_RETARD);
    repeat (4) applyStimulus(1'b0);
    checkOutput("adv_cnt", carrier_counter, 10);
    checkOutput("adv_marker", markSeen - base, 1);
    pulseGroup(2);
    checkOutput("dropped_req_cnt", carrier_counter, 12);

    $display("[TB] advance deferred by a coincident pulse");
    applyStimulus(1'b0, 1'b1, SLIP_ADVANCE);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("defer_cnt", carrier_counter, 14);

    $display("[TB] retard slip at count 20");
    pulseGroup(6);
    applyStimulus(1'b0, 1'b1, SLIP_RETARD);
    repeat (3) applyStimulus(1'b0);
    base = swrSeen;
    applyStimulus(1'b1);
    repeat (4) applyStimulus(1'b0);
    checkOutput("retard_cnt", carrier_counter, 20);
    checkOutput("retard_no_swr", swrSeen - base, 0);
    pulseGroup(1);
    checkOutput("post_retard_cnt", carrier_counter, 21);

    $display("[TB] enable low flushes strobes and holds slip");
    pulseGroup(27);
    base = swrSeen;
    applyStimulus(1'b1);
    applyStimulus(1'b0, 1'b1, SLIP_ADVANCE);
    tbEn = 1'b0;
    repeat (3) applyStimulus(1'b1);
    checkOutput("en_low_pend", slip_pending, 1);
    checkOutput("en_low_cnt", carrier_counter, 49);
    tbEn = 1'b1;
    repeat (4) applyStimulus(1'b0);
    checkOutput("en_low_flush", swrSeen - base, 0);
    checkOutput("en_resume_cnt", carrier_counter, 50);

    $display("[TB] reset two cycles after a marker");
    tbRst = 1'b1;
    applyStimulus(1'b0);
    tbRst = 1'b0;
    base = markSeen;
    base2 = mwrSeen;
    pulseGroup(10);
    checkOutput("pre_rst_marker", markSeen - base, 1);
    tbRst = 1'b1;
    applyStimulus(1'b0);
    tbRst = 1'b0;
    repeat (8) applyStimulus(1'b0);
    checkOutput("rst_no_mwr", mwrSeen - base2, 0);
    checkOutput("rst_sec_zero", second_counter, 0);

    $display("[TB] config error is sticky");
    tbMarker = 120;
    repeat (2) applyStimulus(1'b0);
    checkOutput("cfg_set", config_err, 1);
    tbMarker = MARK;
    repeat (3) applyStimulus(1'b0);
    checkOutput("cfg_sticky", config_err, 1);
    tbRst = 1'b1;
    applyStimulus(1'b0);
    tbRst = 1'b0;
    applyStimulus(1'b0);
    checkOutput("cfg_cleared", config_err, 0);

    repeat (10) applyStimulus(1'b0);
    checkOutput("swr_left", swrQ.size(), 0);
    checkOutput("mwr_left", mwrQ.size(), 0);
    checkOutput("mark_left", markQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msf_timebase.md
MSF_TIMEBASE -- requirements
Module: msf_timebase

Interface
REQ-001 Parameter CNT_W, default 17, width of the carrier counter and the compare ports.
REQ-002 Parameter SECONDS_MINUTE, default 59, last second index before wrap.
REQ-003 Parameter DECIM_LOG2, default 7, second-BRAM write every 2^DECIM_LOG2 carrier pulses.
REQ-004 Parameter SEC_WR_DELAY, default 3, clk cycles from qualifying pulse to second-BRAM strobe.
REQ-005 Parameter MIN_WR_DELAY, default 4, clk cycles from one_sec_marker to minute-BRAM strobe.
REQ-006 clk  in  1  sole clock (normally adc_clk); one clock domain; everything sampled on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  count enable; low freezes the counters and suppresses all strobes.
REQ-009 carrier_pulse  in  1  single-cycle carrier tick.
REQ-010 carrier_max  in  CNT_W  terminal count, e.g. 77499 for Frankfurt or 59999 for MSF.
REQ-011 marker_pos  in  CNT_W  carrier count at which the second boundary is declared.
REQ-012 slip_req  in  1  single-cycle phase-slip request.
REQ-013 slip_dir  in  1  1 = advance one count, 0 = retard one count.
REQ-014 carrier_counter  out  CNT_W  current carrier count, also the second-BRAM address.
REQ-015 second_counter  out  6  0..SECONDS_MINUTE, also the minute-BRAM address.
REQ-016 minute_counter  out  16  free-running minute count.
REQ-017 one_sec_marker / one_min_marker  out  1 each  single-cycle pulses.
REQ-018 write_second_bram / write_minute_bram  out  4 each  byte-enable strobes, all four bits equal.
REQ-019 slip_pending / config_err  out  1 each  status flags.

Function
REQ-020 When en is high, each carrier_pulse increments carrier_counter; if carrier_counter >= carrier_max it loads 0 instead (this also recovers cleanly from a carrier_max reduced below the current count).
REQ-021 one_sec_marker pulses for exactly one cycle, on the first cycle carrier_counter equals marker_pos after having differed; it never repeats while the counter dwells on that value.
REQ-022 The same edge increments second_counter, registered on the cycle after the equality is first seen; the increment wraps from SECONDS_MINUTE to 0.
REQ-023 On that wrap, minute_counter increments (modulo 2^16) and one_min_marker pulses concurrently with one_sec_marker.
REQ-024 write_minute_bram is 4'b1111 for exactly one cycle, MIN_WR_DELAY cycles after one_sec_marker, regardless of subsequent counter motion.
REQ-025 write_second_bram is 4'b1111 for one cycle, SEC_WR_DELAY cycles after a carrier_pulse sampled with carrier_counter[DECIM_LOG2-1:0] == 0 and en high.
REQ-026 slip_req is accepted only when slip_pending is low; it sets slip_pending and latches slip_dir. A request arriving while slip_pending is high is dropped.
REQ-027 Advance: on the first cycle with slip_pending set and no carrier_pulse, carrier_counter increments once, with the same wrap rule as REQ-020. If a carrier_pulse is present in that cycle, the advance is deferred to the next cycle. Every count value is traversed, so the marker still fires.
REQ-028 Retard: the next carrier_pulse is swallowed (no increment, no second-BRAM qualification).
REQ-029 slip_pending clears on the cycle the slip is applied.
REQ-030 en low: counters hold, no markers or strobes are generated, in-flight delay pipelines flush to zero, and slip_pending holds.
REQ-031 config_err is set when marker_pos > carrier_max and is sticky until rst.

Reset
REQ-032 rst zeroes carrier_counter, second_counter, minute_counter, all markers, all strobes, slip_pending, config_err, the delay pipelines and the marker edge history.
REQ-033 rst asserted mid-operation takes effect on the next edge. No strobe that was scheduled before rst is emitted after it.

Structure
REQ-034 Package msf_timebase_pkg holds the default constants FRANKFURT_MAX=77499, MSF_MAX=59999 and DEFAULT_DECIM_LOG2=7, plus the slip-direction constants SLIP_RETARD=0 and SLIP_ADVANCE=1.
REQ-035 The single sub-module msf_strobe_delay (parameter DEPTH, synchronous clear input) implements both strobe delay lines.

Verification
REQ-036 Bench configuration: carrier_max=99, marker_pos=10, pulse every 4 clk, en=1. Required response: counter wraps 99->0, one_sec_marker once per 100 pulses, write_minute_bram exactly 4 cycles after the marker.
REQ-037 SECONDS_MINUTE=3, run 5 seconds -> second_counter 1,2,3,0,1; one_min_marker coincident with the 3->0 step; minute_counter=1.
REQ-038 DECIM_LOG2=2, count 0..15 -> write_second_bram pulses four times, each 3 cycles after the pulses at counts 0,4,8,12.
REQ-039 Advance slip at count 9 -> counter reaches 10 without a carrier pulse and the marker fires. Retard at count 20 -> the next pulse is ignored. A second slip_req while pending is dropped.
REQ-040 rst asserted 2 cycles after a marker -> no write_minute_bram appears. Separately, marker_pos=120 with carrier_max=99 -> config_err=1 and it stays set until rst.
